dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the single-port data memory (word-indexed array, combinational read, negedge byte-masked write).
- Master 0 is the core load/store path; master 1 is the DMA/debug port.
- Arbitrates between the masters, latches the winning request and converts byte address plus size into word index, lane mask and lane-shifted wdata.
- Drives exactly one memory access cycle, then returns an aligned, optionally sign-extended response to the granted master.

Parameters:
- ADDR_W, 32, byte-address width from masters.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- MEM_DEPTH, 1024, memory words; word index = addr[ADDR_W-1:2], truncated to clog2(MEM_DEPTH) bits and zero-extended onto mem_addr.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_req  in  1  request valid, master N (N=0,1); held until mN_gnt.
- mN_we  in  1  1=store, 0=load.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  DATA_W  store data, right-aligned.
- mN_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned.
- mN_signed  in  1  sign-extend load result (ignored for word and store).
- mN_gnt  out  1  request accepted this cycle.
- mN_rsp_valid  out  1  one-cycle response pulse.
- mN_rsp_err  out  1  misaligned/illegal; qualified by rsp_valid.
- mN_rdata  out  DATA_W  load result, right-aligned; 0 for stores/errors.
- mem_cs  out  1  memory chip select.
- mem_rd_en  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_mask  out  4  byte-lane write mask.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr).

Behaviour:
- Reset: state IDLE, last_grant=1 (so M0 wins first tie), all gnt/rsp/mem_* outputs 0, latched request cleared. Reset mid-transaction drops it silently, with no rsp_valid. A store already written at the preceding negedge stays written.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req, gnt is asserted combinationally to the winner in the same cycle.
  - Request fields are latched; next state is ACCESS.
  - The non-winner sees gnt=0 and must hold its request.
  - With no req, stay in IDLE.
- Arbitration: round-robin. The winner is the requester other than last_grant when both request, else the sole requester. last_grant updates on grant.
- ACCESS (exactly one cycle):
  - If aligned: mem_cs=1; mem_rd_en=~we; mem_write=we; mem_addr=latched word index; mem_mask and mem_wdata from the lane table.
  - On the rising edge ending ACCESS, mem_rdata is captured into the response register. Next state is RESP.
  - If misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3): all mem_* stay 0 and err is set.
- Lane table (off = addr[1:0]):
  - byte: mask = 1<<off; wdata byte replicated to all lanes.
  - half: mask = off[1] ? 4'b1100 : 4'b0011; half replicated.
  - word: mask = 4'b1111.
- Load extract: byte/half lane selected by off, then zero- or sign-extended per signed.
- RESP (one cycle):
  - rsp_valid=1, rsp_err and rdata to the granted master only; the other master's rsp outputs are 0.
  - Next state is IDLE; no grant is issued in RESP.
- Latency and throughput: gnt in cycle N, memory access in N+1, rsp_valid in N+2. Maximum one transaction per 3 cycles.
- mem_* outputs are 0 in every state except aligned ACCESS. mN_rdata is 0 whenever rsp_valid=0.
- A req deasserted before gnt is legal and is simply not served.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; M0 always wins when both request, and last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single M0 word store addr=0x10 wdata=0xDEADBEEF, then load addr=0x10 -> store: gnt cycle N, mem_addr=4, mask=1111 in N+1. Load: rsp_valid at N+2 of the load, rdata=0xDEADBEEF, err=0.
- M1 byte store addr=0x13 wdata=0x80, then M1 signed byte load 0x13 and unsigned byte load 0x13 -> store mask=1000, mem_wdata=0x80808080. Loads return 0xFFFFFF80 and 0x00000080.
- Misaligned M0 half load addr=0x21 -> mem_cs/mem_write/mem_rd_en stay 0; rsp_valid at N+2 with err=1, rdata=0.
- Both masters request continuously for 6 transactions -> grants alternate M0,M1,M0,M1,M0,M1 (round-robin). With DMEM_ARB_FIXED_PRIO_EN, all six go to M0.
- Assert reset in the ACCESS cycle of an M1 load -> next cycle IDLE, no rsp_valid ever for that load, all outputs 0. A subsequent M0 request is granted normally.
- Half store addr=0x2 wdata=0xABCD over a word 0x11223344, then word load -> mask=1100, readback 0xABCD3344.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// One master-side request/response port of dmem_arbiter.
// The master modport is the requester; the slave modport is the arbiter side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [1:0]        size;
   logic              is_signed;
   logic              gnt;
   logic              rsp_valid;
   logic              rsp_err;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata, size, is_signed,
      input  gnt, rsp_valid, rsp_err, rdata
   );

   modport slave (
      input  req, we, addr, wdata, size, is_signed,
      output gnt, rsp_valid, rsp_err, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for a single-port data memory: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (M0 wins ties); default is round-robin.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              clk,
   input  logic              reset,
   dmem_arbiter_if.slave     m0,
   dmem_arbiter_if.slave     m1,
   output logic              mem_cs,
   output logic              mem_rd_en,
   output logic              mem_write,
   output logic [3:0]        mem_mask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = off[0];
         2'd2:    misaligned = (off != 2'd0);
         default: misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    lane_mask = 4'b0001 << off;
         2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
         2'd2:    lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] size, input logic [DATA_W-1:0] wd);
      case (size)
         2'd0:    lane_wdata = {4{wd[7:0]}};
         2'd1:    lane_wdata = {2{wd[15:0]}};
         default: lane_wdata = wd;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                      input logic sgn, input logic [DATA_W-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    load_extract = {{24{sgn & b[7]}}, b};
         2'd1:    load_extract = {{16{sgn & h[15]}}, h};
         default: load_extract = word;
      endcase
   endfunction

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic              sgn_q, sgn_d;
   logic              err_q, err_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic              mem_write_q, mem_write_d;
   logic [3:0]        mem_mask_q, mem_mask_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              win_s;
   logic              gnt0_s, gnt1_s;
   logic              req_we_s, req_sgn_s, req_mis_s;
   logic [ADDR_W-1:0] req_addr_s;
   logic [DATA_W-1:0] req_wdata_s;
   logic [1:0]        req_size_s;

   // Arbitration, request latching and per-state sequencing.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      we_d         = we_q;
      size_d       = size_q;
      off_d        = off_q;
      sgn_d        = sgn_q;
      err_d        = err_q;
      mem_cs_d     = mem_cs_q;
      mem_rd_en_d  = mem_rd_en_q;
      mem_write_d  = mem_write_q;
      mem_mask_d   = mem_mask_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_err_d    = rsp_err_q;
      rdata_d      = rdata_q;
      gnt0_s       = 1'b0;
      gnt1_s       = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win_s = ~m0.req;
`else
      if (m0.req && m1.req) begin
         win_s = ~last_grant_q;
      end else begin
         win_s = ~m0.req;
      end
`endif
      if (win_s) begin
         req_we_s    = m1.we;
         req_addr_s  = m1.addr;
         req_wdata_s = m1.wdata;
         req_size_s  = m1.size;
         req_sgn_s   = m1.is_signed;
      end else begin
         req_we_s    = m0.we;
         req_addr_s  = m0.addr;
         req_wdata_s = m0.wdata;
         req_size_s  = m0.size;
         req_sgn_s   = m0.is_signed;
      end
      req_mis_s = misaligned(req_size_s, req_addr_s[1:0]);

      case (state_q)
         IDLE: begin
            if (m0.req || m1.req) begin
               gnt0_s       = ~win_s;
               gnt1_s       = win_s;
               last_grant_d = win_s;
               sel_d        = win_s;
               we_d         = req_we_s;
               size_d       = req_size_s;
               off_d        = req_addr_s[1:0];
               sgn_d        = req_sgn_s;
               err_d        = req_mis_s;
               // A misaligned access keeps the memory bus fully idle.
               mem_cs_d     = ~req_mis_s;
               mem_rd_en_d  = ~req_mis_s & ~req_we_s;
               mem_write_d  = ~req_mis_s & req_we_s;
               mem_mask_d   = req_mis_s ? 4'b0000 : lane_mask(req_size_s, req_addr_s[1:0]);
               mem_addr_d   = req_mis_s ? {ADDR_W{1'b0}}
                                        : {{(ADDR_W-IDX_W){1'b0}}, req_addr_s[IDX_W+1:2]};
               mem_wdata_d  = req_mis_s ? {DATA_W{1'b0}} : lane_wdata(req_size_s, req_wdata_s);
               state_d      = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            mem_cs_d    = 1'b0;
            mem_rd_en_d = 1'b0;
            mem_write_d = 1'b0;
            mem_mask_d  = 4'b0000;
            mem_addr_d  = {ADDR_W{1'b0}};
            mem_wdata_d = {DATA_W{1'b0}};
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rdata_d     = (err_q || we_q) ? {DATA_W{1'b0}} : load_extract(size_q, off_q, sgn_q, mem_rdata);
            state_d     = RESP;
         end
         RESP: begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rdata_d     = {DATA_W{1'b0}};
            state_d     = IDLE;
         end
         default: begin
            mem_cs_d    = 1'b0;
            mem_rd_en_d = 1'b0;
            mem_write_d = 1'b0;
            mem_mask_d  = 4'b0000;
            mem_addr_d  = {ADDR_W{1'b0}};
            mem_wdata_d = {DATA_W{1'b0}};
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rdata_d     = {DATA_W{1'b0}};
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         sel_q        <= 1'b0;
         we_q         <= 1'b0;
         size_q       <= 2'd0;
         off_q        <= 2'd0;
         sgn_q        <= 1'b0;
         err_q        <= 1'b0;
         mem_cs_q     <= 1'b0;
         mem_rd_en_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_mask_q   <= 4'b0000;
         mem_addr_q   <= {ADDR_W{1'b0}};
         mem_wdata_q  <= {DATA_W{1'b0}};
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rdata_q      <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         size_q       <= size_d;
         off_q        <= off_d;
         sgn_q        <= sgn_d;
         err_q        <= err_d;
         mem_cs_q     <= mem_cs_d;
         mem_rd_en_q  <= mem_rd_en_d;
         mem_write_q  <= mem_write_d;
         mem_mask_q   <= mem_mask_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign m0.gnt       = gnt0_s;
   assign m1.gnt       = gnt1_s;
   assign m0.rsp_valid = rsp_valid_q & ~sel_q;
   assign m1.rsp_valid = rsp_valid_q & sel_q;
   assign m0.rsp_err   = rsp_err_q & ~sel_q;
   assign m1.rsp_err   = rsp_err_q & sel_q;
   assign m0.rdata     = sel_q ? {DATA_W{1'b0}} : rdata_q;
   assign m1.rdata     = sel_q ? rdata_q : {DATA_W{1'b0}};

   assign mem_cs    = mem_cs_q;
   assign mem_rd_en = mem_rd_en_q;
   assign mem_write = mem_write_q;
   assign mem_mask  = mem_mask_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
endmodule
